// File: rtl/bcd_score_decoder.sv
// Sequential BCD-to-binary decoder: one digit per clock, MSD first, multiply-by-10-and-add.
// Optional hex decode (dispMode=1) enabled by defining BCD_DECODER_HEX_MODE_EN.
module bcd_score_decoder #(
    parameter int NDIGITS = 5,
    parameter int OUT_W   = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic                   dispMode,
    output logic                   busy,
    output logic                   done,
    output logic [OUT_W-1:0]       value,
    output logic                   err
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [4*NDIGITS-1:0] digits_q;
    logic [OUT_W-1:0]     acc_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 err_acc_q;
    logic [OUT_W-1:0]     value_q;
    logic                 err_q;
    logic                 done_q;

    logic [4*NDIGITS-1:0] digits_shift;
    logic [3:0]           cur_digit;
    logic [OUT_W-1:0]     digit_ext;
    logic [OUT_W-1:0]     acc_dec;
    logic [OUT_W-1:0]     acc_hex;
    logic [OUT_W-1:0]     acc_d;
    logic                 err_acc_d;
    logic                 last_digit;
    logic                 hex_sel;

`ifdef BCD_DECODER_HEX_MODE_EN
    logic mode_q;
    assign hex_sel = mode_q;
`else
    logic unused_disp_mode;
    assign hex_sel          = 1'b0;
    assign unused_disp_mode = dispMode;
`endif

    assign digits_shift = digits_q >> {idx_q, 2'b00};
    assign cur_digit    = digits_shift[3:0];
    assign digit_ext    = {{(OUT_W-4){1'b0}}, cur_digit};
    // x*10 built from shifts so no multiplier is inferred
    assign acc_dec      = (acc_q << 3) + (acc_q << 1) + digit_ext;
    assign acc_hex      = (acc_q << 4) | digit_ext;
    assign acc_d        = hex_sel ? acc_hex : acc_dec;
    assign err_acc_d    = err_acc_q | (!hex_sel && (cur_digit > 4'd9));
    assign last_digit   = (idx_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_digit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ACCUM);
        done  = done_q;
        value = value_q;
        err   = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q  <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            err_acc_q <= 1'b0;
            value_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_DECODER_HEX_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    digits_q  <= digits;
                    acc_q     <= '0;
                    idx_q     <= IDX_W'(NDIGITS - 1);
                    err_acc_q <= 1'b0;
`ifdef BCD_DECODER_HEX_MODE_EN
                    mode_q    <= dispMode;
`endif
                end
            end else begin
                acc_q     <= acc_d;
                err_acc_q <= err_acc_d;
                idx_q     <= idx_q - IDX_W'(1);
                // Result register only moves on completion so it holds between conversions
                if (last_digit) begin
                    value_q <= err_acc_d ? '0 : acc_d;
                    err_q   <= err_acc_d;
                    done_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_decoder.sv
// Randomized self-checking bench for bcd_score_decoder against a positional-arithmetic model.
// Expectations follow BCD_DECODER_HEX_MODE_EN when it is defined for the build.
module tb_bcd_score_decoder;

    localparam int NDIGITS = 5;
    localparam int OUT_W   = 20;
`ifdef BCD_DECODER_HEX_MODE_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic               start;
    logic [19:0]        digits;
    logic               dispMode;
    logic               busy;
    logic               done;
    logic [OUT_W-1:0]   value;
    logic               err;

    int checks = 0;
    int errors = 0;

    bcd_score_decoder #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .digits(digits), .dispMode(dispMode),
        .busy(busy), .done(done), .value(value), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {err, value} from sum of nibble * 10^position, or the raw nibbles in hex mode
    function automatic logic [20:0] model(input logic [19:0] d, input logic m);
        int v;
        bit bad;
        int n;
        v = 0;
        bad = 1'b0;
        if (HEX_EN && m) return {1'b0, d};
        for (int i = 0; i < NDIGITS; i++) begin
            n = int'((d >> (4 * i)) & 20'hF);
            if (n > 9) bad = 1'b1;
            v = v + n * (10 ** i);
        end
        if (bad) return {1'b1, 20'd0};
        return {1'b0, v[19:0]};
    endfunction

    // Runs one conversion; returns observations only, callers compare
    task automatic run_conv(input logic [19:0] d, input logic m, output logic [19:0] v,
                            output logic e, output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        digits = d; dispMode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        v = value;
        e = err;
        if (busy !== 1'b0) busy_ok = 1'b0;
        @(negedge clk);
        pulse_ok = (done === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; digits = '0; dispMode = 1'b0;
        #12;
        checks++;
        if ({busy, done, err, value} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b err=%0b value=%h required all 0", busy, done, err, value);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [19:0] v; logic e; int lat; bit bok, pok;
        run_conv(20'h12345, 1'b0, v, e, lat, bok, pok);
        checks++;
        if (lat != NDIGITS + 1) begin
            errors++; $display("FAIL basic_latency got %0d required %0d", lat, NDIGITS + 1);
        end
        checks++;
        if (!bok) begin
            errors++; $display("FAIL basic_busy got busy profile wrong required high until done");
        end
        checks++;
        if (!pok) begin
            errors++; $display("FAIL basic_done_pulse got done extended required single cycle");
        end
        checks++;
        if (v !== 20'h03039 || e !== 1'b0) begin
            errors++; $display("FAIL basic_value got %h err=%0b required 03039 err=0", v, e);
        end
    endtask

    task automatic test_patterns();
        logic [19:0] tbl [4];
        logic [19:0] v; logic e; int lat; bit bok, pok; logic [20:0] exp;
        tbl[0] = 20'h99999; tbl[1] = 20'h00000; tbl[2] = 20'h12A45; tbl[3] = 20'h00007;
        for (int i = 0; i < 4; i++) begin
            run_conv(tbl[i], 1'b0, v, e, lat, bok, pok);
            exp = model(tbl[i], 1'b0);
            checks++;
            if ({e, v} !== exp || lat != NDIGITS + 1 || !pok) begin
                errors++;
                $display("FAIL pattern_%h got err=%0b value=%h lat=%0d required err=%0b value=%h lat=%0d",
                         tbl[i], e, v, lat, exp[20], exp[19:0], NDIGITS + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone; logic [19:0] v;
        ndone = 0; v = '0;
        @(negedge clk);
        digits = 20'h54321; dispMode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        digits = 20'h11111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin ndone++; v = value; end
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL ignore_start_done_count got %0d required 1", ndone);
        end
        checks++;
        if (v !== 20'h0D431) begin
            errors++; $display("FAIL ignore_start_value got %h required 0d431", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] vals [3];
        logic [20:0] exp;
        int j;
        vals[0] = 20'h00042; vals[1] = 20'h31415; vals[2] = 20'h99999;
        j = 0;
        @(negedge clk);
        digits = vals[0]; dispMode = 1'b0; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                exp = model(vals[j], 1'b0);
                checks++;
                if ({err, value} !== exp || c != (NDIGITS + 1) * (j + 1)) begin
                    errors++;
                    $display("FAIL back_to_back_%0d got value=%h err=%0b cycle=%0d required value=%h err=%0b cycle=%0d",
                             j, value, err, c, exp[19:0], exp[20], (NDIGITS + 1) * (j + 1));
                end
                j++;
                if (j < 3) digits = vals[j];
                else start = 1'b0;
            end
            if (j == 3) break;
        end
        start = 1'b0;
        checks++;
        if (j != 3) begin
            errors++; $display("FAIL back_to_back_count got %0d required 3", j);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        @(negedge clk);
        digits = 20'h12345; dispMode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || value === 20'd0) begin
            errors++; $display("FAIL reset_mid_precondition got busy=%0b value=%h required busy=1 value nonzero", busy, value);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, value} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs busy=%0b done=%0b err=%0b value=%h required all 0", busy, done, err, value);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL reset_mid_no_done got %0d active cycles required 0", ndone);
        end
    endtask

    task automatic test_hex();
        logic [19:0] v; logic e; int lat; bit bok, pok; logic [20:0] exp;
        exp = HEX_EN ? 21'h0ABCDE : {1'b1, 20'd0};
        run_conv(20'hABCDE, 1'b1, v, e, lat, bok, pok);
        checks++;
        if ({e, v} !== exp || lat != NDIGITS + 1) begin
            errors++;
            $display("FAIL hex_abcde got err=%0b value=%h lat=%0d required err=%0b value=%h", e, v, lat, exp[20], exp[19:0]);
        end
    endtask

    task automatic test_random();
        logic [19:0] d; logic m; logic [19:0] v; logic e; int lat; bit bok, pok; logic [20:0] exp;
        for (int i = 0; i < 25; i++) begin
            for (int n = 0; n < NDIGITS; n++) begin
                if ($urandom_range(0, 7) == 0) d[4*n +: 4] = 4'($urandom_range(10, 15));
                else d[4*n +: 4] = 4'($urandom_range(0, 9));
            end
            m = 1'($urandom_range(0, 1));
            run_conv(d, m, v, e, lat, bok, pok);
            exp = model(d, m);
            checks++;
            if ({e, v} !== exp || lat != NDIGITS + 1 || !bok || !pok) begin
                errors++;
                $display("FAIL random_%0d digits=%h mode=%0b got err=%0b value=%h lat=%0d required err=%0b value=%h lat=%0d",
                         i, d, m, e, v, lat, exp[20], exp[19:0], NDIGITS + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_hex();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
